// File: rtl/tt_rv32_serial_bridge.sv
// Pin-level bridge: assembles an instruction (and optional read data) from narrow
// beats, steps the RV32 core for one cycle, then streams the ALU result back out.
module tt_rv32_serial_bridge #(
  parameter int PIN_W = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             pin_in_valid,
  input  logic             pin_in_mode,
  output logic             pin_in_ready,
  output logic [PIN_W-1:0] pin_out,
  output logic             pin_out_valid,
  input  logic             pin_out_ready,
  output logic             pin_out_last,
  output logic             pin_out_we,
  output logic [XLEN-1:0]  core_instr,
  output logic [XLEN-1:0]  core_read_data,
  output logic             core_step,
  input  logic [XLEN-1:0]  core_alu_result,
  input  logic [XLEN-1:0]  core_addr,
  input  logic             core_write_enable,
  output logic [XLEN-1:0]  addr_q,
  output logic [CNT_W-1:0] instr_count
);

  localparam int BEATS = XLEN / PIN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [BW-1:0] BEAT_ZERO = BW'(0);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    LOAD_INSTR = 2'd0,
    LOAD_DATA  = 2'd1,
    EXEC       = 2'd2,
    SHIFT_OUT  = 2'd3
  } state_t;

  state_t                       state_r;
  logic [BW-1:0]                beat_r;
  logic                         mode_r;
  logic                         mode_next_s;
  logic [BEATS-1:0][PIN_W-1:0]  instr_r;
  logic [BEATS-1:0][PIN_W-1:0]  rdata_r;
  logic [BEATS-1:0][PIN_W-1:0]  result_r;

  assign core_instr     = instr_r;
  assign core_read_data = rdata_r;

  // Mode is taken live on beat 0 so a single-beat word routes correctly
  always_comb begin
    if (beat_r == BEAT_ZERO) begin
      mode_next_s = pin_in_mode;
    end else begin
      mode_next_s = mode_r;
    end
  end

  // Handshake and beat-select outputs, decoded from state and counter only
  always_comb begin
    pin_in_ready  = (state_r == LOAD_INSTR) || (state_r == LOAD_DATA);
    core_step     = (state_r == EXEC);
    pin_out_valid = (state_r == SHIFT_OUT);
    pin_out_last  = pin_out_valid && (beat_r == LAST_BEAT);
    if (pin_out_valid) begin
      pin_out = result_r[beat_r];
    end else begin
      pin_out = {PIN_W{1'b0}};
    end
  end

  // Sequencer: load beats, step the core once, shift the result out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOAD_INSTR;
      beat_r      <= BEAT_ZERO;
      mode_r      <= 1'b0;
      instr_r     <= {XLEN{1'b0}};
      rdata_r     <= {XLEN{1'b0}};
      result_r    <= {XLEN{1'b0}};
      addr_q      <= {XLEN{1'b0}};
      pin_out_we  <= 1'b0;
      instr_count <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        LOAD_INSTR: begin
          if (pin_in_valid) begin
            instr_r[beat_r] <= pin_in;
            mode_r          <= mode_next_s;
            if (beat_r == LAST_BEAT) begin
              beat_r  <= BEAT_ZERO;
              state_r <= mode_next_s ? LOAD_DATA : EXEC;
            end else begin
              beat_r <= beat_r + BEAT_ONE;
            end
          end
        end
        LOAD_DATA: begin
          if (pin_in_valid) begin
            rdata_r[beat_r] <= pin_in;
            if (beat_r == LAST_BEAT) begin
              beat_r  <= BEAT_ZERO;
              state_r <= EXEC;
            end else begin
              beat_r <= beat_r + BEAT_ONE;
            end
          end
        end
        EXEC: begin
          result_r    <= core_alu_result;
          addr_q      <= core_addr;
          pin_out_we  <= core_write_enable;
          instr_count <= instr_count + CNT_W'(1);
          state_r     <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (pin_out_ready) begin
            if (beat_r == LAST_BEAT) begin
              beat_r     <= BEAT_ZERO;
              pin_out_we <= 1'b0;
              state_r    <= LOAD_INSTR;
            end else begin
              beat_r <= beat_r + BEAT_ONE;
            end
          end
        end
        default: begin
          beat_r  <= BEAT_ZERO;
          state_r <= LOAD_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_rv32_serial_bridge.sv
// Self-checking bench: transaction-level model of the bridge (expected beats queue,
// instruction/read-data/count model) plus directed runs on 8-, 4- and 32-bit pin widths.
module tb_tt_rv32_serial_bridge;

  logic        clk;
  logic        rst;
  logic [7:0]  pin_in;
  logic        pin_in_valid, pin_in_mode, pin_in_ready;
  logic [7:0]  pin_out;
  logic        pin_out_valid, pin_out_ready, pin_out_last, pin_out_we;
  logic [31:0] core_instr, core_read_data, core_alu_result, core_addr, addr_q;
  logic        core_step, core_write_enable;
  logic [15:0] instr_count;

  logic [3:0]  p4_in, p4_out;
  logic        p4_valid, p4_mode, p4_ready, p4_out_valid, p4_out_ready, p4_last, p4_we, p4_step;
  logic [31:0] p4_instr, p4_rd, p4_addr_q;
  logic [3:0]  p4_cnt;

  logic [31:0] p32_in, p32_out;
  logic        p32_valid, p32_mode, p32_ready, p32_out_valid, p32_out_ready, p32_last, p32_we, p32_step;
  logic [31:0] p32_instr, p32_rd, p32_addr_q;
  logic [15:0] p32_cnt;

  tt_rv32_serial_bridge u_dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .pin_in_valid(pin_in_valid),
    .pin_in_mode(pin_in_mode), .pin_in_ready(pin_in_ready), .pin_out(pin_out),
    .pin_out_valid(pin_out_valid), .pin_out_ready(pin_out_ready), .pin_out_last(pin_out_last),
    .pin_out_we(pin_out_we), .core_instr(core_instr), .core_read_data(core_read_data),
    .core_step(core_step), .core_alu_result(core_alu_result), .core_addr(core_addr),
    .core_write_enable(core_write_enable), .addr_q(addr_q), .instr_count(instr_count)
  );

  tt_rv32_serial_bridge #(.PIN_W(4), .XLEN(32), .CNT_W(4)) u_p4 (
    .clk(clk), .rst(rst), .pin_in(p4_in), .pin_in_valid(p4_valid),
    .pin_in_mode(p4_mode), .pin_in_ready(p4_ready), .pin_out(p4_out),
    .pin_out_valid(p4_out_valid), .pin_out_ready(p4_out_ready), .pin_out_last(p4_last),
    .pin_out_we(p4_we), .core_instr(p4_instr), .core_read_data(p4_rd),
    .core_step(p4_step), .core_alu_result(core_alu_result), .core_addr(core_addr),
    .core_write_enable(core_write_enable), .addr_q(p4_addr_q), .instr_count(p4_cnt)
  );

  tt_rv32_serial_bridge #(.PIN_W(32), .XLEN(32), .CNT_W(16)) u_p32 (
    .clk(clk), .rst(rst), .pin_in(p32_in), .pin_in_valid(p32_valid),
    .pin_in_mode(p32_mode), .pin_in_ready(p32_ready), .pin_out(p32_out),
    .pin_out_valid(p32_out_valid), .pin_out_ready(p32_out_ready), .pin_out_last(p32_last),
    .pin_out_we(p32_we), .core_instr(p32_instr), .core_read_data(p32_rd),
    .core_step(p32_step), .core_alu_result(core_alu_result), .core_addr(core_addr),
    .core_write_enable(core_write_enable), .addr_q(p32_addr_q), .instr_count(p32_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t       mq[$];
  logic [7:0]  got[$];
  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;
  int          steps  = 0;
  logic        prev_step = 1'b0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] exp_rd    = 32'h0;
  logic [31:0] exp_addr  = 32'h0;
  logic        exp_we    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of the 8-bit DUT against the transaction model
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mcount    = 0;
      prev_step = 1'b0;
    end else begin
      if (core_step) begin
        chk("step_instr", core_instr, exp_instr);
        chk("step_rdata", core_read_data, exp_rd);
        chk("step_in_ready", pin_in_ready, 1'b0);
        chk("step_count", instr_count, mcount);
        chk("step_single", prev_step, 1'b0);
        steps++;
        mcount = (mcount + 1) % 65536;
      end
      if (pin_out_valid) begin
        if (mq.size() == 0) begin
          chk("out_unexpected", 1'b1, 1'b0);
        end else begin
          chk("out_data", pin_out, mq[0].data);
          chk("out_last", pin_out_last, mq[0].last);
          if (pin_out_ready) begin
            got.push_back(pin_out);
            void'(mq.pop_front());
          end
        end
        chk("out_in_ready", pin_in_ready, 1'b0);
        chk("out_we", pin_out_we, exp_we);
        chk("out_addr", addr_q, exp_addr);
        chk("out_count", instr_count, mcount);
        chk("out_instr", core_instr, exp_instr);
      end else begin
        chk("idle_last", pin_out_last, 1'b0);
      end
      prev_step = core_step;
    end
  end

  task automatic send_word(input logic [31:0] w, input logic mode, input int nb);
    int n;
    for (int k = 0; k < nb; k++) begin
      pin_in       = w[k*8 +: 8];
      pin_in_mode  = mode;
      pin_in_valid = 1'b1;
      n = 0;
      while (!pin_in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 20) chk("in_ready_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    pin_in_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] instr, input logic mode, input logic [31:0] data,
                         input logic [31:0] res, input logic [31:0] addr, input logic we,
                         input int stall_beat, input int stall_n, input logic garbage);
    int n;
    int s0;
    core_alu_result   = res;
    core_addr         = addr;
    core_write_enable = we;
    exp_instr = instr;
    if (mode) exp_rd = data;
    exp_we   = we;
    exp_addr = addr;
    for (int k = 0; k < 4; k++) mq.push_back('{data: res[k*8 +: 8], last: (k == 3)});
    got.delete();
    s0 = steps;
    pin_out_ready = 1'b1;
    send_word(instr, mode, 4);
    if (mode) send_word(data, 1'b0, 4);
    if (garbage) begin
      pin_in       = 8'hFF;
      pin_in_valid = 1'b1;
    end
    n = 0;
    while (!pin_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 10) chk("out_valid_timeout", 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        pin_out_ready = 1'b0;
        repeat (stall_n) begin
          @(posedge clk); #1;
        end
        pin_out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    pin_in_valid = 1'b0;
    chk("post_out_valid", pin_out_valid, 1'b0);
    chk("post_we", pin_out_we, 1'b0);
    chk("post_in_ready", pin_in_ready, 1'b1);
    chk("step_pulses", steps - s0, 1);
    chk("beats_out", got.size(), 4);
    chk("model_drained", mq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    pin_in = 8'h0; pin_in_valid = 1'b0; pin_in_mode = 1'b0; pin_out_ready = 1'b0;
    core_alu_result = 32'h0; core_addr = 32'h0; core_write_enable = 1'b0;
    p4_in = 4'h0; p4_valid = 1'b0; p4_mode = 1'b0; p4_out_ready = 1'b1;
    p32_in = 32'h0; p32_valid = 1'b0; p32_mode = 1'b0; p32_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", core_instr, 32'h0);
    chk("rst_rdata", core_read_data, 32'h0);
    chk("rst_addr", addr_q, 32'h0);
    chk("rst_count", instr_count, 16'h0);
    chk("rst_we", pin_out_we, 1'b0);
    chk("rst_step", core_step, 1'b0);
    chk("rst_out_valid", pin_out_valid, 1'b0);
    chk("rst_out", pin_out, 8'h0);
    chk("rst_in_ready", pin_in_ready, 1'b1);
    rst = 1'b0;

    // Basic mode-0 instruction
    run_txn(32'h00500093, 1'b0, 32'h0, 32'h00000005, 32'h00000100, 1'b0, -1, 0, 1'b0);
    chk("t1_instr", core_instr, 32'h00500093);
    chk("t1_count", instr_count, 16'd1);
    chk("t1_beats", {got[3], got[2], got[1], got[0]}, 32'h00000005);
    chk("t1_addr", addr_q, 32'h00000100);

    // Load with read data
    run_txn(32'h00002083, 1'b1, 32'hDEADBEEF, 32'h00000008, 32'h00000008, 1'b0, -1, 0, 1'b0);
    chk("t2_rdata", core_read_data, 32'hDEADBEEF);
    chk("t2_instr", core_instr, 32'h00002083);
    chk("t2_count", instr_count, 16'd2);

    // Output backpressure on beat 1; read data must be retained under mode 0
    run_txn(32'h002081B3, 1'b0, 32'h0, 32'h11223344, 32'h00000010, 1'b0, 1, 3, 1'b0);
    chk("t3_seq", {got[0], got[1], got[2], got[3]}, 32'h44332211);
    chk("t3_rdata_kept", core_read_data, 32'hDEADBEEF);

    // Store with garbage valid held during exec/shift
    run_txn(32'h0020A023, 1'b0, 32'h0, 32'h00000040, 32'h00000040, 1'b1, -1, 0, 1'b1);
    chk("t4_instr", core_instr, 32'h0020A023);
    chk("t4_count", instr_count, 16'd4);
    chk("t4_addr", addr_q, 32'h00000040);

    // Reset after two partial beats
    send_word(32'h0000BBAA, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 32'h0;
    chk("mid_rst_count", instr_count, 16'h0);
    chk("mid_rst_instr", core_instr, 32'h0);
    chk("mid_rst_in_ready", pin_in_ready, 1'b1);
    run_txn(32'h00500093, 1'b0, 32'h0, 32'h00000005, 32'h00000004, 1'b0, -1, 0, 1'b0);
    chk("t5_instr", core_instr, 32'h00500093);
    chk("t5_count", instr_count, 16'd1);
    chk("t5_rdata", core_read_data, 32'h0);

    // Single-beat bridge
    core_alu_result = 32'hCAFEF00D;
    p32_in = 32'h00500093;
    p32_valid = 1'b1;
    chk("p32_in_ready", p32_ready, 1'b1);
    @(posedge clk); #1;
    p32_valid = 1'b0;
    chk("p32_step", p32_step, 1'b1);
    chk("p32_instr", p32_instr, 32'h00500093);
    @(posedge clk); #1;
    chk("p32_out_valid", p32_out_valid, 1'b1);
    chk("p32_last", p32_last, 1'b1);
    chk("p32_out", p32_out, 32'hCAFEF00D);
    chk("p32_count", p32_cnt, 16'd1);
    @(posedge clk); #1;
    chk("p32_done", p32_out_valid, 1'b0);
    chk("p32_ready_back", p32_ready, 1'b1);

    // Eight-beat bridge with a 4-bit counter: 17 runs cross the wrap
    core_alu_result = 32'h89ABCDEF;
    for (int r = 0; r < 17; r++) begin
      for (int k = 0; k < 8; k++) begin
        chk("p4_in_ready", p4_ready, 1'b1);
        p4_in    = core_alu_result[k*4 +: 4] ^ 4'h0;
        p4_in    = (32'h00500093 >> (k * 4)) & 32'hF;
        p4_valid = 1'b1;
        @(posedge clk); #1;
      end
      p4_valid = 1'b0;
      chk("p4_step", p4_step, 1'b1);
      chk("p4_instr", p4_instr, 32'h00500093);
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
        chk("p4_out", p4_out, (32'h89ABCDEF >> (k * 4)) & 32'hF);
        chk("p4_last", p4_last, (k == 7));
        @(posedge clk); #1;
      end
      chk("p4_count", p4_cnt, (r + 1) % 16);
      if (r == 15) chk("p4_wrap", p4_cnt, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_rv32_serial_bridge.md
Name: tt_rv32_serial_bridge

Overview:
Parametrised pin-level bridge between a narrow TinyTapeout-style pin bus and the single-cycle RV32 datapath. It assembles a full XLEN instruction, plus optional load read-data, from PIN_W-wide beats, then steps the core for exactly one cycle. It captures alu_result, addr and write_enable, and streams alu_result back out in PIN_W-wide beats. This replaces direct 8-bit instruction feeding with full-width, flow-controlled operation.

Parameters:
PIN_W, 8, pin bus width in bits; XLEN must be an integer multiple of PIN_W
XLEN, 32, core data/instruction width
BEATS, XLEN/PIN_W (derived localparam), beats per word
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pin_in  in  PIN_W  inbound beat data
pin_in_valid  in  1  inbound beat valid
pin_in_mode  in  1  sampled on first instruction beat; 1 = also load a read-data word
pin_in_ready  out  1  bridge accepts inbound beat
pin_out  out  PIN_W  outbound beat data
pin_out_valid  out  1  outbound beat valid
pin_out_ready  in  1  consumer accepts outbound beat
pin_out_last  out  1  current outbound beat is final
pin_out_we  out  1  captured core write_enable, held during output phase
core_instr  out  XLEN  instruction to core
core_read_data  out  XLEN  read data to core
core_step  out  1  core clock-enable, one-cycle pulse
core_alu_result  in  XLEN  core ALU result
core_addr  in  XLEN  core data address
core_write_enable  in  1  core store strobe
addr_q  out  XLEN  captured core_addr
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (rst=1 at clk edge) has priority over everything, including mid-operation:
  - state=LOAD_INSTR, beat counter=0.
  - core_instr, core_read_data, addr_q, result reg, pin_out_we and instr_count all 0.
  - mode reg=0; core_step=0, pin_out_valid=0, pin_out_last=0, pin_out=0.
  - pin_in_ready=1 from the first cycle after reset.
- Beat order is little-endian: beat k carries bits [k*PIN_W +: PIN_W].
- A transfer occurs when valid&&ready at a clk edge.
- LOAD_INSTR:
  - pin_in_ready=1.
  - On beat 0 acceptance, latch pin_in_mode.
  - Each accepted beat is written into core_instr at the counter slice; counter increments.
  - On acceptance of beat BEATS-1: counter clears; next state LOAD_DATA if mode=1, else EXEC.
- LOAD_DATA:
  - pin_in_ready=1; beats fill core_read_data the same way.
  - After the last beat, next state EXEC.
  - When mode=0, core_read_data keeps its previous value.
- EXEC, exactly one cycle:
  - pin_in_ready=0, core_step=1.
  - At the edge, capture core_alu_result into result reg, core_addr into addr_q, core_write_enable into pin_out_we.
  - instr_count increments, wrapping at 2^CNT_W.
  - Next state SHIFT_OUT.
- SHIFT_OUT:
  - pin_out_valid=1, pin_out = result reg beat at counter, pin_out_last=(counter==BEATS-1).
  - Beat advances only when pin_out_ready=1; pin_out stays stable while stalled.
  - After the last beat is accepted: counter clears; pin_out_valid, pin_out_last and pin_out_we go to 0; next state LOAD_INSTR.
  - pin_in_ready re-asserts the next cycle, not the same cycle.
- pin_in_valid outside load states is ignored; no data is consumed.
- All outputs are registered except pin_in_ready, core_step, pin_out, pin_out_valid and pin_out_last, which are decoded from state and counter only. These have no combinational path from inputs.
- BEATS=1 (PIN_W==XLEN) is legal: one-beat load and one-beat output, with pin_out_last=1.
- Minimum turnaround with mode=0 and continuous valid/ready: 2*BEATS+1 cycles per instruction.

Test Plan:
- Reset, then instruction beats 0x93,0x00,0x50,0x00 with mode=0, model alu_result=0x00000005 -> core_instr=0x00500093, one core_step pulse, pin_out 0x05,0x00,0x00,0x00, last on 4th beat, instr_count=1.
- Mode=1 load sequence, instr beats 0x83,0x20,0x00,0x00 then data 0xEF,0xBE,0xAD,0xDE -> core_read_data=0xDEADBEEF at step; core_step high exactly 1 cycle.
- Output backpressure: hold pin_out_ready=0 for 3 cycles at beat 1 with result 0x11223344 -> pin_out holds 0x33 stable, no beat loss, sequence 0x44,0x33,0x22,0x11.
- Assert rst during LOAD_INSTR after 2 beats, then send a full new instruction -> partial beats discarded, new instr assembled correctly, instr_count=0 before execution.
- pin_in_valid held high during EXEC/SHIFT_OUT with garbage 0xFF -> no change to core_instr; pin_in_ready=0 throughout.
- Parameter sweep PIN_W=32 and PIN_W=4 with the same instruction -> correct assembly; BEATS=1 and BEATS=8 beat counts; instr_count wraps from 0xFFFF to 0 when preset via 65536 runs (or forced in a short bench).
